// File: rtl/arp_rewrite_pkg.sv
// Shared constants and types for the ARP next-hop rewrite stage:
// header field offsets, ARP entry layout, port encodings and FSM states.
package arp_rewrite_pkg;

  localparam int MAC_HI = 255;
  localparam int MAC_LO = 208;
  localparam int TTL_HI = 79;
  localparam int TTL_LO = 72;
  localparam int CK_HI  = 63;
  localparam int CK_LO  = 48;

  // ARP entry: {valid, MAC[47:0], IP[31:0]}
  localparam int ENT_W      = 81;
  localparam int ENT_VALID  = 80;
  localparam int ENT_MAC_HI = 79;
  localparam int ENT_MAC_LO = 32;
  localparam int ENT_IP_HI  = 31;
  localparam int ENT_IP_LO  = 0;

  localparam logic [7:0] PORT_OQ0 = 8'h01;
  localparam logic [7:0] PORT_OQ1 = 8'h04;
  localparam logic [7:0] PORT_OQ2 = 8'h10;
  localparam logic [7:0] PORT_OQ3 = 8'h40;
  localparam logic [7:0] PORT_OQ4 = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_HEADER,
    ST_PAYLOAD
  } state_t;

  typedef enum logic [1:0] {
    DEC_PASS,
    DEC_TTL,
    DEC_MISS,
    DEC_HIT
  } decision_t;

  function automatic logic [7:0] oq_port(input logic [2:0] oq);
    logic [7:0] p;
    case (oq)
      3'd0:    p = PORT_OQ0;
      3'd1:    p = PORT_OQ1;
      3'd2:    p = PORT_OQ2;
      3'd3:    p = PORT_OQ3;
      3'd4:    p = PORT_OQ4;
      default: p = 8'h00;
    endcase
    return p;
  endfunction

  // Each physical port bit 2k has its CPU queue at bit 2k+1.
  function automatic logic [7:0] cpu_port(input logic [7:0] src);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 4; k++) p[2*k+1] = src[2*k];
    return p;
  endfunction

endpackage

// File: rtl/arp_rewrite_if.sv
// AXI-Stream bundle used on both sides of the ARP rewrite stage.
interface arp_rewrite_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
) ();
  logic [DATA_W-1:0]   TDATA;
  logic [DATA_W/8-1:0] TSTRB;
  logic [USER_W-1:0]   TUSER;
  logic                TVALID;
  logic                TLAST;
  logic                TREADY;

  modport master (output TDATA, TSTRB, TUSER, TVALID, TLAST, input TREADY);
  modport slave  (input TDATA, TSTRB, TUSER, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/arp_rewrite_cam.sv
// ARP table: write port, registered read port and a parallel IP match
// where the lowest matching valid index wins.
module arp_cam
  import arp_rewrite_pkg::*;
#(
  parameter int NUM_ENTRIES = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_req,
  input  logic [$clog2(NUM_ENTRIES)-1:0] wr_addr,
  input  logic [ENT_W-1:0]               wr_data,
  output logic                           wr_ack,
  input  logic                           rd_req,
  input  logic [$clog2(NUM_ENTRIES)-1:0] rd_addr,
  output logic [ENT_W-1:0]               rd_data,
  output logic                           rd_ack,
  input  logic [31:0]                    key,
  output logic                           match_hit,
  output logic [47:0]                    match_mac
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [47:0]            mac_q [NUM_ENTRIES];
  logic [31:0]            ip_q  [NUM_ENTRIES];
  logic [IDX_W-1:0]       match_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      wr_ack  <= 1'b0;
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      wr_ack <= wr_req;
      rd_ack <= rd_req;
      if (wr_req) valid_q[wr_addr] <= wr_data[ENT_VALID];
      if (rd_req) rd_data <= {valid_q[rd_addr], mac_q[rd_addr], ip_q[rd_addr]};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_req) begin
      mac_q[wr_addr] <= wr_data[ENT_MAC_HI:ENT_MAC_LO];
      ip_q[wr_addr]  <= wr_data[ENT_IP_HI:ENT_IP_LO];
    end
  end

  // Scan downward so the lowest matching index is the last one assigned.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && ip_q[i] == key) begin
        match_hit = 1'b1;
        match_idx = i[IDX_W-1:0];
      end
    end
  end

  assign match_mac = mac_q[match_idx];

endmodule

// File: rtl/arp_rewrite.sv
// Next-hop resolution and header rewrite: looks up the next-hop IP in the
// ARP table, then rewrites MAC/TTL/checksum or diverts the packet to the CPU.
module arp_rewrite
  import arp_rewrite_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24,
  parameter int NUM_ENTRIES          = 32
) (
  input  logic                           AXI_ACLK,
  input  logic                           AXI_RESET,
  arp_rewrite_if.slave                   S_AXIS,
  arp_rewrite_if.master                  M_AXIS,
  input  logic                           arp_lookup,
  input  logic [31:0]                    nh_reg,
  input  logic [31:0]                    oq_reg,
  input  logic                           tbl_wr_req,
  input  logic [$clog2(NUM_ENTRIES)-1:0] tbl_wr_addr,
  input  logic [ENT_W-1:0]               tbl_wr_data,
  output logic                           tbl_wr_ack,
  input  logic                           tbl_rd_req,
  input  logic [$clog2(NUM_ENTRIES)-1:0] tbl_rd_addr,
  output logic [ENT_W-1:0]               tbl_rd_data,
  output logic                           tbl_rd_ack,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]  reset,
  output logic [C_S_AXI_DATA_WIDTH-1:0]  arp_miss_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]  ttl_exp_count
);

  state_t    state_q, state_d;
  decision_t dec_d, dec_p1;
  logic [47:0] mac_p1;
  logic [7:0]  port_d, port_p1;
  logic        match_hit;
  logic [47:0] match_mac;
  logic [7:0]  ttl;

  function automatic logic [15:0] cksum_patch(input logic [15:0] ck);
    logic [16:0] sum;
    sum = {1'b0, ck} + 17'h00100;
    return sum[15:0] + {15'd0, sum[16]};
  endfunction

  function automatic logic [C_M_AXIS_DATA_WIDTH-1:0] rewrite_hdr(
    input logic [C_S_AXIS_DATA_WIDTH-1:0] d, input logic [47:0] mac);
    logic [C_M_AXIS_DATA_WIDTH-1:0] r;
    r = d;
    r[MAC_HI:MAC_LO] = mac;
    r[TTL_HI:TTL_LO] = d[TTL_HI:TTL_LO] - 8'd1;
    r[CK_HI:CK_LO]   = cksum_patch(d[CK_HI:CK_LO]);
    return r;
  endfunction

  function automatic logic [C_M_AXIS_TUSER_WIDTH-1:0] set_dst(
    input logic [C_S_AXIS_TUSER_WIDTH-1:0] u, input logic [7:0] port);
    logic [C_M_AXIS_TUSER_WIDTH-1:0] r;
    r = u;
    r[DST_PORT_POS +: 8] = port;
    return r;
  endfunction

  arp_cam #(.NUM_ENTRIES(NUM_ENTRIES)) u_cam (
    .clk       (AXI_ACLK),
    .rst       (AXI_RESET),
    .wr_req    (tbl_wr_req),
    .wr_addr   (tbl_wr_addr),
    .wr_data   (tbl_wr_data),
    .wr_ack    (tbl_wr_ack),
    .rd_req    (tbl_rd_req),
    .rd_addr   (tbl_rd_addr),
    .rd_data   (tbl_rd_data),
    .rd_ack    (tbl_rd_ack),
    .key       (nh_reg),
    .match_hit (match_hit),
    .match_mac (match_mac)
  );

  // LOOKUP decision: header beat is already held on S_AXIS while TREADY=0
  assign ttl = S_AXIS.TDATA[TTL_HI:TTL_LO];

  always_comb begin
    dec_d = DEC_HIT;
    if (!arp_lookup)                           dec_d = DEC_PASS;
    else if (ttl <= 8'd1)                      dec_d = DEC_TTL;
    else if (!match_hit || oq_reg > 32'd4)     dec_d = DEC_MISS;
    port_d = (dec_d == DEC_HIT) ? oq_port(oq_reg[2:0])
                                : cpu_port(S_AXIS.TUSER[SRC_PORT_POS +: 8]);
  end

  // Stage p1: decision registered at the end of LOOKUP
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      state_q <= ST_IDLE;
      dec_p1  <= DEC_PASS;
      mac_p1  <= '0;
      port_p1 <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_LOOKUP) begin
        dec_p1  <= dec_d;
        mac_p1  <= match_mac;
        port_p1 <= port_d;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    S_AXIS.TREADY = 1'b0;
    M_AXIS.TDATA  = '0;
    M_AXIS.TSTRB  = '0;
    M_AXIS.TUSER  = '0;
    M_AXIS.TVALID = 1'b0;
    M_AXIS.TLAST  = 1'b0;
    case (state_q)
      ST_IDLE:   if (S_AXIS.TVALID) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_HEADER;
      ST_HEADER: begin
        S_AXIS.TREADY = M_AXIS.TREADY;
        M_AXIS.TVALID = S_AXIS.TVALID;
        M_AXIS.TLAST  = S_AXIS.TLAST;
        M_AXIS.TSTRB  = S_AXIS.TSTRB;
        M_AXIS.TDATA  = (dec_p1 == DEC_HIT) ? rewrite_hdr(S_AXIS.TDATA, mac_p1)
                                            : S_AXIS.TDATA;
        M_AXIS.TUSER  = (dec_p1 == DEC_PASS) ? S_AXIS.TUSER
                                             : set_dst(S_AXIS.TUSER, port_p1);
        if (S_AXIS.TVALID && M_AXIS.TREADY)
          state_d = S_AXIS.TLAST ? ST_IDLE : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        S_AXIS.TREADY = M_AXIS.TREADY;
        M_AXIS.TVALID = S_AXIS.TVALID;
        M_AXIS.TLAST  = S_AXIS.TLAST;
        M_AXIS.TSTRB  = S_AXIS.TSTRB;
        M_AXIS.TDATA  = S_AXIS.TDATA;
        M_AXIS.TUSER  = S_AXIS.TUSER;
        if (S_AXIS.TVALID && M_AXIS.TREADY && S_AXIS.TLAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Software clear overrides a same-cycle increment
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      arp_miss_count <= '0;
      ttl_exp_count  <= '0;
    end else if (reset == C_S_AXI_DATA_WIDTH'(1)) begin
      arp_miss_count <= '0;
      ttl_exp_count  <= '0;
    end else if (state_q == ST_LOOKUP) begin
      if (dec_d == DEC_MISS) arp_miss_count <= arp_miss_count + C_S_AXI_DATA_WIDTH'(1);
      if (dec_d == DEC_TTL)  ttl_exp_count  <= ttl_exp_count + C_S_AXI_DATA_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_arp_rewrite.sv
// Bench for arp_rewrite: directed and randomized packets checked against a
// shadow ARP table and rule-level model of the expected output beats.
module tb_arp_rewrite;

  typedef struct {
    logic [255:0] data;
    logic [127:0] user;
    logic [31:0]  strb;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arp_rewrite_if #(.DATA_W(256), .USER_W(128)) s_if ();
  arp_rewrite_if #(.DATA_W(256), .USER_W(128)) m_if ();

  logic        arp_lookup;
  logic [31:0] nh_reg, oq_reg;
  logic        tbl_wr_req, tbl_wr_ack, tbl_rd_req, tbl_rd_ack;
  logic [4:0]  tbl_wr_addr, tbl_rd_addr;
  logic [80:0] tbl_wr_data, tbl_rd_data;
  logic [31:0] sw_reset, arp_miss_count, ttl_exp_count;

  arp_rewrite dut (
    .AXI_ACLK       (clk),
    .AXI_RESET      (rst),
    .S_AXIS         (s_if),
    .M_AXIS         (m_if),
    .arp_lookup     (arp_lookup),
    .nh_reg         (nh_reg),
    .oq_reg         (oq_reg),
    .tbl_wr_req     (tbl_wr_req),
    .tbl_wr_addr    (tbl_wr_addr),
    .tbl_wr_data    (tbl_wr_data),
    .tbl_wr_ack     (tbl_wr_ack),
    .tbl_rd_req     (tbl_rd_req),
    .tbl_rd_addr    (tbl_rd_addr),
    .tbl_rd_data    (tbl_rd_data),
    .tbl_rd_ack     (tbl_rd_ack),
    .reset          (sw_reset),
    .arp_miss_count (arp_miss_count),
    .ttl_exp_count  (ttl_exp_count)
  );

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];
  bit          tv   [32];
  logic [47:0] tmac [32];
  logic [31:0] tip  [32];
  int m_miss = 0;
  int m_ttl  = 0;
  bit bp = 1'b0;
  logic [255:0] hdr_data;
  logic [127:0] hdr_user;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Rule-level model: what the packet must look like after the stage.
  task automatic model_pkt(input beat_t in[$], input bit lk, input logic [31:0] nh,
                           input logic [31:0] oq);
    beat_t h;
    int idx;
    int s;
    logic [7:0] ttl, src, cpu;
    logic [7:0] pt [5];
    pt = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h02};
    idx = -1;
    for (int i = 0; i < 32; i++)
      if (tv[i] && tip[i] == nh) begin idx = i; break; end
    h   = in[0];
    ttl = h.data[79:72];
    src = h.user[23:16];
    cpu = (src & 8'h55) << 1;
    if (lk) begin
      if (ttl <= 8'd1) begin
        h.user[31:24] = cpu;
        m_ttl++;
      end else if (idx < 0 || oq > 32'd4) begin
        h.user[31:24] = cpu;
        m_miss++;
      end else begin
        h.data[255:208] = tmac[idx];
        h.data[79:72]   = ttl - 8'd1;
        s = int'(h.data[63:48]) + 256;
        if (s > 65535) s = s - 65535;
        h.data[63:48]   = s[15:0];
        h.user[31:24]   = pt[oq];
      end
    end
    exp_q.push_back(h);
    for (int i = 1; i < in.size(); i++) exp_q.push_back(in[i]);
  endtask

  task automatic mk_pkt(output beat_t q[$], input int n, input logic [7:0] ttl,
                        input logic [15:0] ck, input logic [7:0] src);
    beat_t b;
    q = {};
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 8; w++) b.data[w*32 +: 32] = $urandom();
      for (int w = 0; w < 4; w++) b.user[w*32 +: 32] = $urandom();
      b.strb = (i == n - 1) ? (32'($urandom()) | 32'h1) : 32'hFFFF_FFFF;
      b.last = (i == n - 1);
      if (i == 0) begin
        b.data[79:72]  = ttl;
        b.data[63:48]  = ck;
        b.user[23:16]  = src;
      end
      q.push_back(b);
    end
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic send_pkt(input beat_t b[$], input bit lk, input logic [31:0] nh,
                          input logic [31:0] oq, input bit lat);
    int cnt;
    bit rdy;
    model_pkt(b, lk, nh, oq);
    arp_lookup = lk;
    nh_reg     = nh;
    oq_reg     = oq;
    for (int i = 0; i < b.size(); i++) begin
      s_if.TDATA  = b[i].data;
      s_if.TUSER  = b[i].user;
      s_if.TSTRB  = b[i].strb;
      s_if.TLAST  = b[i].last;
      s_if.TVALID = 1'b1;
      cnt = 0;
      do begin
        @(negedge clk);
        if (lat && i == 0 && cnt < 3) chk("hdr_latency", m_if.TVALID, (cnt == 2));
        rdy = s_if.TREADY;
        @(posedge clk); #1;
        cnt++;
      end while (!rdy && cnt < 300);
      chk("beat_accepted", rdy, 1'b1);
      if (!rdy) break;
    end
    s_if.TVALID = 1'b0;
    s_if.TLAST  = 1'b0;
  endtask

  task automatic tbl_write(input logic [4:0] a, input bit v, input logic [47:0] mac,
                           input logic [31:0] ip);
    tbl_wr_req  = 1'b1;
    tbl_wr_addr = a;
    tbl_wr_data = {v, mac, ip};
    @(posedge clk); #1;
    tbl_wr_req = 1'b0;
    chk("wr_ack", tbl_wr_ack, 1'b1);
    tv[a] = v; tmac[a] = mac; tip[a] = ip;
    @(posedge clk); #1;
    chk("wr_ack_pulse", tbl_wr_ack, 1'b0);
  endtask

  task automatic tbl_read(input logic [4:0] a, output logic [80:0] d);
    tbl_rd_req  = 1'b1;
    tbl_rd_addr = a;
    @(posedge clk); #1;
    tbl_rd_req = 1'b0;
    chk("rd_ack", tbl_rd_ack, 1'b1);
    d = tbl_rd_data;
  endtask

  task automatic drain();
    int cnt = 0;
    while (exp_q.size() > 0 && cnt < 500) begin @(posedge clk); #1; cnt++; end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    m_if.TREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output checker: every handshake against the model, every stall for stability.
  initial begin
    beat_t e;
    bit first = 1'b1;
    bit pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [255:0] pd;
    logic [127:0] pu;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pv && !pr) begin
          chk("stall_valid", m_if.TVALID, 1'b1);
          chk("stall_data", m_if.TDATA, pd);
          chk("stall_user", m_if.TUSER, pu);
          chk("stall_last", m_if.TLAST, pl);
        end
        if (m_if.TVALID && m_if.TREADY) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat actual=%0h expected=none", m_if.TDATA);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", m_if.TDATA, e.data);
            chk("out_user", m_if.TUSER, e.user);
            chk("out_strb", m_if.TSTRB, e.strb);
            chk("out_last", m_if.TLAST, e.last);
          end
          if (first) begin hdr_data = m_if.TDATA; hdr_user = m_if.TUSER; end
          first = m_if.TLAST;
        end
      end
      pv = m_if.TVALID; pr = m_if.TREADY; pl = m_if.TLAST;
      pd = m_if.TDATA;  pu = m_if.TUSER;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    beat_t p[$];
    logic [80:0] d;
    logic [31:0] nh;
    int tsel;
    logic [7:0] ttl, src;
    arp_lookup = 0; nh_reg = 0; oq_reg = 0; sw_reset = 0;
    tbl_wr_req = 0; tbl_wr_addr = 0; tbl_wr_data = 0;
    tbl_rd_req = 0; tbl_rd_addr = 0;
    s_if.TVALID = 0; s_if.TLAST = 0; s_if.TDATA = 0; s_if.TUSER = 0; s_if.TSTRB = 0;
    m_if.TREADY = 1;
    for (int i = 0; i < 32; i++) begin tv[i] = 0; tmac[i] = 0; tip[i] = 0; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", m_if.TVALID, 1'b0);
    chk("rst_s_tready", s_if.TREADY, 1'b0);
    chk("rst_m_tdata", m_if.TDATA, 256'd0);
    chk("rst_miss_cnt", arp_miss_count, 32'd0);
    chk("rst_ttl_cnt", ttl_exp_count, 32'd0);
    chk("rst_wr_ack", tbl_wr_ack, 1'b0);
    chk("rst_rd_ack", tbl_rd_ack, 1'b0);
    chk("rst_rd_data", tbl_rd_data, 81'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    tbl_read(5'd7, d);
    chk("rst_entry_invalid", d[80], 1'b0);
    tbl_write(5'd3, 1'b1, 48'h0A0B0C0D0E0F, 32'hC0A80101);
    tbl_read(5'd3, d);
    chk("rd_entry3", d, 81'h1_0A0B0C0D0E0F_C0A80101);

    mk_pkt(p, 2, 8'd64, 16'h1234, 8'h01);
    send_pkt(p, 1'b1, 32'hC0A80101, 32'd2, 1'b1);
    drain();
    chk("hit_mac", hdr_data[255:208], 48'h0A0B0C0D0E0F);
    chk("hit_ttl", hdr_data[79:72], 8'd63);
    chk("hit_cksum", hdr_data[63:48], 16'h1334);
    chk("hit_dst", hdr_user[31:24], 8'h10);

    mk_pkt(p, 1, 8'd20, 16'hFF00, 8'h40);
    send_pkt(p, 1'b1, 32'hC0A80101, 32'd4, 1'b1);
    drain();
    chk("wrap_cksum", hdr_data[63:48], 16'h0001);
    chk("oq4_dst", hdr_user[31:24], 8'h02);

    mk_pkt(p, 3, 8'd64, 16'hABCD, 8'h04);
    send_pkt(p, 1'b1, 32'hC0A80199, 32'd1, 1'b1);
    drain();
    chk("miss_dst", hdr_user[31:24], 8'h08);
    chk("miss_data", hdr_data, p[0].data);
    chk("miss_cnt", arp_miss_count, 32'd1);
    sw_reset = 32'd2;
    @(posedge clk); #1 sw_reset = 32'd0;
    chk("miss_cnt_not_cleared", arp_miss_count, 32'd1);
    sw_reset = 32'd1;
    @(posedge clk); #1 sw_reset = 32'd0;
    chk("miss_cnt_cleared", arp_miss_count, 32'd0);
    m_miss = 0; m_ttl = 0;

    mk_pkt(p, 2, 8'd1, 16'h5555, 8'h10);
    send_pkt(p, 1'b1, 32'hC0A80101, 32'd0, 1'b0);
    drain();
    chk("ttl_dst", hdr_user[31:24], 8'h20);
    chk("ttl_data", hdr_data, p[0].data);
    chk("ttl_cnt", ttl_exp_count, 32'd1);

    mk_pkt(p, 2, 8'd64, 16'h1234, 8'h01);
    send_pkt(p, 1'b0, 32'hC0A80101, 32'd2, 1'b0);
    drain();
    chk("pass_data", hdr_data, p[0].data);
    chk("pass_user", hdr_user, p[0].user);

    bp = 1'b1;
    mk_pkt(p, 5, 8'd33, 16'h0F0F, 8'h04);
    send_pkt(p, 1'b1, 32'hC0A80101, 32'd3, 1'b1);
    mk_pkt(p, 1, 8'd33, 16'h0F0F, 8'h01);
    send_pkt(p, 1'b1, 32'hC0A80101, 32'd1, 1'b1);
    drain();
    bp = 1'b0;

    tbl_write(5'd5, 1'b1, 48'h555555555555, 32'hC0A80202);
    tbl_write(5'd2, 1'b1, 48'h222222222222, 32'hC0A80202);
    mk_pkt(p, 1, 8'd9, 16'h0000, 8'h01);
    send_pkt(p, 1'b1, 32'hC0A80202, 32'd0, 1'b0);
    drain();
    chk("dup_lowest_mac", hdr_data[255:208], 48'h222222222222);
    mk_pkt(p, 2, 8'd9, 16'h0000, 8'h01);
    fork
      send_pkt(p, 1'b1, 32'hC0A80202, 32'd0, 1'b0);
      begin @(posedge clk); #1; tbl_write(5'd2, 1'b1, 48'hBEEFBEEFBEEF, 32'hC0A80202); end
    join
    drain();
    chk("wr_in_lookup_old_mac", hdr_data[255:208], 48'h222222222222);
    mk_pkt(p, 1, 8'd9, 16'h0000, 8'h01);
    send_pkt(p, 1'b1, 32'hC0A80202, 32'd0, 1'b0);
    drain();
    chk("new_mac", hdr_data[255:208], 48'hBEEFBEEFBEEF);

    tbl_wr_req = 1'b1; tbl_wr_addr = 5'd2; tbl_wr_data = {1'b1, 48'h123456789ABC, 32'hC0A80202};
    tbl_rd_req = 1'b1; tbl_rd_addr = 5'd2;
    @(posedge clk); #1;
    tbl_wr_req = 1'b0; tbl_rd_req = 1'b0;
    chk("rdwr_same_old", tbl_rd_data, 81'h1_BEEFBEEFBEEF_C0A80202);
    tmac[2] = 48'h123456789ABC;
    @(posedge clk); #1;
    tbl_read(5'd2, d);
    chk("rdwr_new", d, 81'h1_123456789ABC_C0A80202);

    for (int i = 8; i < 16; i++)
      tbl_write(5'(i), ($urandom_range(0, 4) != 0), {16'h00AA, 32'($urandom())}, 32'h0A000000 + i);
    for (int n = 0; n < 40; n++) begin
      bp   = ($urandom_range(0, 1) == 1);
      nh   = 32'h0A000000 + $urandom_range(6, 17);
      tsel = $urandom_range(0, 3);
      ttl  = (tsel == 0) ? 8'd0 : (tsel == 1) ? 8'd1 : 8'($urandom_range(2, 255));
      src  = 8'h01 << (2 * $urandom_range(0, 3));
      mk_pkt(p, $urandom_range(1, 5), ttl, 16'($urandom()), src);
      send_pkt(p, ($urandom_range(0, 9) != 0), nh, $urandom_range(0, 6), 1'b1);
      if ($urandom_range(0, 4) == 0) begin
        tsel = $urandom_range(8, 15);
        tbl_write(5'(tsel), 1'b1, {16'h00BB, 32'($urandom())}, 32'h0A000000 + tsel);
        tbl_read(5'(tsel), d);
        chk("rand_rd", d, {tv[tsel], tmac[tsel], tip[tsel]});
      end
    end
    bp = 1'b0;
    drain();
    chk("final_miss_cnt", arp_miss_count, 32'(m_miss));
    chk("final_ttl_cnt", ttl_exp_count, 32'(m_ttl));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
